// File: rtl/apb_regbank_pkg.sv
// Shared types and defaults for the APB register-bank completer.
// The phase enum is used both for the current-cycle class and the phase register.
package apb_regbank_pkg;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2,
        PH_ERROR  = 2'd3
    } phase_t;

    localparam int unsigned NUM_SLV_DEF  = 3;
    localparam int unsigned DEPTH_DEF    = 16;
    localparam int unsigned ADDR_LSB_DEF = 2;

    // Select vectors are zero-extended to 32 bits by the caller.
    function automatic logic is_onehot(input logic [31:0] v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/apb_regbank_mem.sv
// One DEPTH x 32 register bank: async-reset flops, one write port,
// one combinational read port.
module apb_regbank_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_regbank_slave.sv
// APB completer with one register bank per select line. Classifies every cycle
// as IDLE/SETUP/ACCESS/ERROR, commits only legal transfers, flags the rest.
module apb_regbank_slave
    import apb_regbank_pkg::*;
#(
    parameter int unsigned NUM_SLV  = NUM_SLV_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned ADDR_LSB = ADDR_LSB_DEF
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic [NUM_SLV-1:0] Pselx,
    input  logic               Penable,
    input  logic               Pwrite,
    input  logic [31:0]        Paddr,
    input  logic [31:0]        Pwdata,
    input  logic               err_clr,
    output logic [31:0]        Prdata,
    output logic               err,
    output logic [15:0]        wr_cnt,
    output logic [15:0]        rd_cnt
);

    localparam int unsigned IDXW = $clog2(DEPTH);

    phase_t             cls;
    phase_t             prev_q, prev_d;
    logic [NUM_SLV-1:0] sel_q, sel_d;
    logic [31:0]        addr_q, addr_d;
    logic               wr_q, wr_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [15:0]        wr_cnt_q, wr_cnt_d;
    logic [15:0]        rd_cnt_q, rd_cnt_d;

    logic [IDXW-1:0]    idx;
    logic [31:0]        bank_rd [NUM_SLV];
    logic [NUM_SLV-1:0] bank_we;
    logic [31:0]        sel_word;
    logic               sel_onehot;

    assign idx        = Paddr[ADDR_LSB +: IDXW];
    assign sel_onehot = is_onehot(32'(Pselx));

    // ACCESS must repeat the captured SETUP exactly; anything unclassified is ERROR.
    always_comb begin
        cls = PH_ERROR;
        if (Pselx == '0 && !Penable) begin
            cls = PH_IDLE;
        end else if (sel_onehot && !Penable) begin
            cls = PH_SETUP;
        end else if (sel_onehot && Penable && prev_q == PH_SETUP &&
                     Pselx == sel_q && Paddr == addr_q && Pwrite == wr_q) begin
            cls = PH_ACCESS;
        end
    end

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (Pselx[i]) begin
                sel_word |= bank_rd[i];
            end
        end
    end

    assign bank_we = (cls == PH_ACCESS && wr_q) ? sel_q : '0;

    for (genvar g = 0; g < NUM_SLV; g++) begin : g_bank
        apb_regbank_mem #(
            .DEPTH (DEPTH),
            .AW    (IDXW)
        ) u_mem (
            .clk_i   (Hclk),
            .rst_ni  (Hresetn),
            .we_i    (bank_we[g]),
            .waddr_i (idx),
            .wdata_i (Pwdata),
            .raddr_i (idx),
            .rdata_o (bank_rd[g])
        );
    end

    always_comb begin
        prev_d   = (cls == PH_ERROR) ? PH_IDLE : cls;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (cls == PH_SETUP) begin
            sel_d   = Pselx;
            addr_d  = Paddr;
            wr_d    = Pwrite;
            rdata_d = sel_word;
        end
        if (cls == PH_ACCESS) begin
            if (wr_q && wr_cnt_q != '1) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end
            if (!wr_q && rd_cnt_q != '1) begin
                rd_cnt_d = rd_cnt_q + 16'd1;
            end
        end
        // A new violation wins over a simultaneous clear.
        err_d = (cls == PH_ERROR) ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            prev_q   <= PH_IDLE;
            sel_q    <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            prev_q   <= prev_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign Prdata = (cls == PH_ACCESS && !wr_q) ? rdata_q : '0;
    assign err    = err_q;
    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;

endmodule
